// File: rtl/pipeline_skid_register_if.sv
// pipeline_skid_register_if: in/out valid-ready bundle; master = surrounding stages, slave = register
interface pipeline_skid_register_if #(parameter int DATA_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            occupancy;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, occupancy);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, occupancy);
endinterface

// File: rtl/pipeline_skid_register.sv
// pipeline_skid_register: valid/ready stage register with flush and optional 2-entry skid; ports clk, reset (async), flush, bus (slave: in_*/out_*/occupancy)
module pipeline_skid_register #(
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
  parameter bit                    ENABLE_SKID    = 1'b1,
  parameter bit                    CLEAR_ON_FLUSH = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  input logic                     flush,
  pipeline_skid_register_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic                  in_ready, out_valid, in_fire, out_fire;
  assign out_valid = state_q != EMPTY;
  // skid mode decodes ready from registered state only; single-register mode keeps the legacy stall path
  assign in_ready = !reset && (ENABLE_SKID ? state_q != SKID : (state_q == EMPTY || bus.out_ready));
  assign in_fire = bus.in_valid && in_ready;
  assign out_fire = out_valid && bus.out_ready;
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data = main_q;
  assign bus.occupancy = state_q;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: begin
        state_d = in_fire ? FULL : EMPTY;
        main_d = in_fire ? bus.in_data : main_q;
      end
      FULL: begin
        state_d = in_fire ? (out_fire || !ENABLE_SKID ? FULL : SKID) : (out_fire ? EMPTY : FULL);
        main_d = in_fire && (out_fire || !ENABLE_SKID) ? bus.in_data : main_q;
        skid_d = in_fire && !out_fire && ENABLE_SKID ? bus.in_data : skid_q;
      end
      SKID: begin
        state_d = out_fire ? FULL : SKID;
        main_d = out_fire ? skid_q : main_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d = CLEAR_ON_FLUSH ? RESET_VALUE : main_q;
      skid_d = CLEAR_ON_FLUSH ? RESET_VALUE : skid_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
endmodule
